// File: rtl/wombat_pkg.sv
// Shared types and default sizes for the wombat register file blocks.
// Used by the command parser and the readback responder.
package wombat_pkg;

   localparam int WOMBAT_WORD_WIDTH = 8;
   localparam int WOMBAT_REG_DEPTH  = 16;
   localparam int WOMBAT_REG_WIDTH  = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HEADER,
      ST_SEND
   } state_e;

   typedef logic [WOMBAT_WORD_WIDTH*WOMBAT_REG_WIDTH-1:0] reg_word_t;

endpackage

// File: rtl/wombat_reg_readback.sv
// Register readback responder: snapshots one register and streams its words.
// Optional address header word enabled by WOMBAT_READBACK_HEADER_EN.
module wombat_reg_readback
   import wombat_pkg::*;
#(
   parameter int WORD_WIDTH    = WOMBAT_WORD_WIDTH,
   parameter int REG_DEPTH     = WOMBAT_REG_DEPTH,
   parameter int REG_WIDTH     = WOMBAT_REG_WIDTH,
   parameter bit LITTLE_ENDIAN = 1'b0,
   localparam int ADDR_WIDTH   = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1
) (
   input  logic                            clk,
   input  logic                            i_reset_n,
   input  logic [WORD_WIDTH*REG_WIDTH-1:0] i_mem [REG_DEPTH],
   input  logic                            i_req_valid,
   output logic                            o_req_ready,
   input  logic [ADDR_WIDTH-1:0]           i_req_addr,
   output logic [WORD_WIDTH-1:0]           o_tx_data,
   output logic                            o_tx_valid,
   input  logic                            i_tx_ready,
   output logic                            o_busy
);

   localparam int REG_BITS = WORD_WIDTH * REG_WIDTH;
   localparam int IDX_W    = (REG_WIDTH > 1) ? $clog2(REG_WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REG_WIDTH - 1);

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [REG_BITS-1:0] snap_q, snap_d;
   logic [WORD_WIDTH-1:0] word_sel;
   int                  pos;
`ifdef WOMBAT_READBACK_HEADER_EN
   logic [WORD_WIDTH-1:0] hdr_q, hdr_d;
`endif

   // Word 0 is the top slice in big-endian order, the bottom slice otherwise.
   always_comb begin
      pos = LITTLE_ENDIAN ? int'(idx_q) : (REG_WIDTH - 1 - int'(idx_q));
      word_sel = WORD_WIDTH'(snap_q >> (pos * WORD_WIDTH));
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      snap_d      = snap_q;
`ifdef WOMBAT_READBACK_HEADER_EN
      hdr_d       = hdr_q;
`endif
      o_req_ready = 1'b0;
      o_busy      = 1'b1;
      o_tx_valid  = 1'b1;
      o_tx_data   = word_sel;
      case (state_q)
         ST_IDLE: begin
            o_req_ready = 1'b1;
            o_busy      = 1'b0;
            o_tx_valid  = 1'b0;
            o_tx_data   = '0;
            if (i_req_valid) begin
               snap_d = (int'(i_req_addr) < REG_DEPTH) ?
                        i_mem[i_req_addr] : '0;
               idx_d  = '0;
`ifdef WOMBAT_READBACK_HEADER_EN
               hdr_d   = WORD_WIDTH'(i_req_addr);
               state_d = ST_HEADER;
`else
               state_d = ST_SEND;
`endif
            end
         end
`ifdef WOMBAT_READBACK_HEADER_EN
         ST_HEADER: begin
            o_tx_data = hdr_q;
            if (i_tx_ready) state_d = ST_SEND;
         end
`endif
         ST_SEND: begin
            if (i_tx_ready) begin
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = ST_IDLE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: begin
            o_req_ready = 1'b0;
            o_busy      = 1'b0;
            o_tx_valid  = 1'b0;
            o_tx_data   = '0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!i_reset_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         snap_q  <= '0;
`ifdef WOMBAT_READBACK_HEADER_EN
         hdr_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         snap_q  <= snap_d;
`ifdef WOMBAT_READBACK_HEADER_EN
         hdr_q   <= hdr_d;
`endif
      end
   end

endmodule

// File: tb/tb_wombat_reg_readback.sv
// Bench for wombat_reg_readback: big- and little-endian instances share stimulus.
// Expected words come from a queue model filled at each accepted request.
module tb_wombat_reg_readback;
   import wombat_pkg::*;

`ifdef WOMBAT_READBACK_HEADER_EN
   localparam int HDR = 1;
`else
   localparam int HDR = 0;
`endif
   localparam int NW = 4 + HDR;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic [3:0]  req_addr;
   logic        tx_ready;
   reg_word_t   mem [16];

   logic [7:0]  data_be, data_le;
   logic        valid_be, valid_le;
   logic        rdy_be, rdy_le;
   logic        busy_be, busy_le;

   logic [7:0]  be_q[$];
   logic [7:0]  le_q[$];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   wombat_reg_readback #(.LITTLE_ENDIAN(1'b0)) dut_be (
      .clk(clk), .i_reset_n(rst_n), .i_mem(mem),
      .i_req_valid(req_valid), .o_req_ready(rdy_be),
      .i_req_addr(req_addr), .o_tx_data(data_be),
      .o_tx_valid(valid_be), .i_tx_ready(tx_ready), .o_busy(busy_be)
   );

   wombat_reg_readback #(.LITTLE_ENDIAN(1'b1)) dut_le (
      .clk(clk), .i_reset_n(rst_n), .i_mem(mem),
      .i_req_valid(req_valid), .o_req_ready(rdy_le),
      .i_req_addr(req_addr), .o_tx_data(data_le),
      .o_tx_valid(valid_le), .i_tx_ready(tx_ready), .o_busy(busy_le)
   );

   // Advance one clock and update the word queues from the pre-edge inputs.
   task automatic tick();
      logic acc, hs;
      logic [31:0] v;
      logic [3:0] a;
      acc = rst_n && req_valid && (be_q.size() == 0);
      hs  = rst_n && tx_ready && (be_q.size() != 0);
      a   = req_addr;
      v   = mem[a];
      @(posedge clk);
      if (!rst_n) begin
         be_q.delete();
         le_q.delete();
      end else if (hs) begin
         void'(be_q.pop_front());
         void'(le_q.pop_front());
      end else if (acc) begin
         if (HDR == 1) begin
            be_q.push_back({4'h0, a});
            le_q.push_back({4'h0, a});
         end
         for (int k = 0; k < 4; k++) begin
            be_q.push_back(8'((v >> (8 * (3 - k))) & 32'hFF));
            le_q.push_back(8'((v >> (8 * k)) & 32'hFF));
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = 1'b0;
      req_addr = '0;
      tx_ready = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (valid_be !== 1'b0 || valid_le !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_valid got %b/%b exp 0", valid_be, valid_le);
      end
      n_cmp++;
      if (data_be !== 8'h00 || data_le !== 8'h00) begin
         n_bad++;
         $display("FAIL reset_data got %h/%h exp 00", data_be, data_le);
      end
      n_cmp++;
      if (busy_be !== 1'b0 || busy_le !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_busy got %b/%b exp 0", busy_be, busy_le);
      end
      n_cmp++;
      if (rdy_be !== 1'b1 || rdy_le !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_ready got %b/%b exp 1", rdy_be, rdy_le);
      end
      tick();
   endtask

   task automatic test_word_order();
      logic [7:0] exp_be[$];
      logic [7:0] exp_le[$];
      exp_be = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      exp_le = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
      if (HDR == 1) begin
         exp_be.push_front(8'h01);
         exp_le.push_front(8'h01);
      end
      mem[1] = 32'hA1B2C3D4;
      req_addr = 4'd1;
      req_valid = 1'b1;
      tx_ready = 1'b1;
      tick();
      req_valid = 1'b0;
      for (int k = 0; k < NW; k++) begin
         n_cmp++;
         if (valid_be !== 1'b1 || data_be !== exp_be[k]) begin
            n_bad++;
            $display("FAIL order_be[%0d] got v=%b %h exp v=1 %h",
                     k, valid_be, data_be, exp_be[k]);
         end
         n_cmp++;
         if (valid_le !== 1'b1 || data_le !== exp_le[k]) begin
            n_bad++;
            $display("FAIL order_le[%0d] got v=%b %h exp v=1 %h",
                     k, valid_le, data_le, exp_le[k]);
         end
         tick();
      end
      n_cmp++;
      if (busy_be !== 1'b0 || valid_be !== 1'b0 || busy_le !== 1'b0) begin
         n_bad++;
         $display("FAIL order_done got busy=%b valid=%b exp 0 0",
                  busy_be, valid_be);
      end
   endtask

   task automatic test_backpressure_snapshot();
      logic [7:0] held;
      mem[1] = 32'hA1B2C3D4;
      req_addr = 4'd1;
      req_valid = 1'b1;
      tx_ready = 1'b1;
      tick();
      req_valid = 1'b0;
      for (int k = 0; k < HDR + 1; k++) tick();
      tx_ready = 1'b0;
      held = data_le;
      for (int c = 0; c < 3; c++) begin
         n_cmp++;
         if (valid_be !== 1'b1 || data_be !== 8'hB2) begin
            n_bad++;
            $display("FAIL bp_hold_be got v=%b %h exp v=1 b2",
                     valid_be, data_be);
         end
         n_cmp++;
         if (data_le !== held || data_le !== le_q[0]) begin
            n_bad++;
            $display("FAIL bp_hold_le got %h exp %h", data_le, le_q[0]);
         end
         if (c == 1) mem[1] = 32'h0;
         tick();
      end
      tx_ready = 1'b1;
      tick();
      n_cmp++;
      if (data_be !== 8'hC3 || data_le !== 8'hB2) begin
         n_bad++;
         $display("FAIL snap_w2 got %h/%h exp c3/b2", data_be, data_le);
      end
      tick();
      n_cmp++;
      if (data_be !== 8'hD4 || data_le !== 8'hA1) begin
         n_bad++;
         $display("FAIL snap_w3 got %h/%h exp d4/a1", data_be, data_le);
      end
      tick();
      n_cmp++;
      if (valid_be !== 1'b0 || rdy_be !== 1'b1) begin
         n_bad++;
         $display("FAIL snap_end got v=%b r=%b exp 0 1", valid_be, rdy_be);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_be[$];
      int guard;
      exp_be = '{8'h00, 8'h00, 8'h00, 8'h01};
      if (HDR == 1) exp_be.push_front(8'h00);
      mem[0] = 32'h00000001;
      mem[1] = 32'hA1B2C3D4;
      req_addr = 4'd1;
      req_valid = 1'b1;
      tx_ready = 1'b1;
      tick();
      req_addr = 4'd0;
      guard = 0;
      while (be_q.size() != 0 && guard < 20) begin
         n_cmp++;
         if (rdy_be !== 1'b0 || busy_be !== 1'b1 || data_be !== be_q[0]) begin
            n_bad++;
            $display("FAIL b2b_busy got r=%b b=%b %h exp 0 1 %h",
                     rdy_be, busy_be, data_be, be_q[0]);
         end
         tick();
         guard++;
      end
      n_cmp++;
      if (rdy_be !== 1'b1 || guard != NW) begin
         n_bad++;
         $display("FAIL b2b_ready got r=%b cycles=%0d exp 1 %0d",
                  rdy_be, guard, NW);
      end
      tick();
      req_valid = 1'b0;
      for (int k = 0; k < NW; k++) begin
         n_cmp++;
         if (valid_be !== 1'b1 || data_be !== exp_be[k]) begin
            n_bad++;
            $display("FAIL b2b_word[%0d] got v=%b %h exp v=1 %h",
                     k, valid_be, data_be, exp_be[k]);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      mem[1] = 32'hA1B2C3D4;
      req_addr = 4'd1;
      req_valid = 1'b1;
      tx_ready = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      n_cmp++;
      if (valid_be !== 1'b0 || valid_le !== 1'b0) begin
         n_bad++;
         $display("FAIL rstmid_valid got %b/%b exp 0", valid_be, valid_le);
      end
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (rdy_be !== 1'b1 || busy_be !== 1'b0) begin
         n_bad++;
         $display("FAIL rstmid_ready got r=%b b=%b exp 1 0", rdy_be, busy_be);
      end
      for (int c = 0; c < 5; c++) begin
         tick();
         n_cmp++;
         if (valid_be !== 1'b0 || valid_le !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_tail got %b/%b exp 0", valid_be, valid_le);
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 7) == 0)
            mem[$urandom_range(0, 15)] = $urandom;
         req_valid = ($urandom_range(0, 3) == 0);
         req_addr = 4'($urandom_range(0, 15));
         tx_ready = ($urandom_range(0, 3) != 0);
         #1;
         n_cmp++;
         if (valid_be !== (be_q.size() != 0) ||
             rdy_be !== (be_q.size() == 0) ||
             busy_be !== (be_q.size() != 0)) begin
            n_bad++;
            $display("FAIL rand_ctl c=%0d got v=%b r=%b b=%b exp pending=%0d",
                     c, valid_be, rdy_be, busy_be, be_q.size());
         end
         if (be_q.size() != 0) begin
            n_cmp++;
            if (data_be !== be_q[0] || data_le !== le_q[0]) begin
               n_bad++;
               $display("FAIL rand_data c=%0d got %h/%h exp %h/%h",
                        c, data_be, data_le, be_q[0], le_q[0]);
            end
         end
         tick();
      end
      req_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_word_order();
      test_backpressure_snapshot();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
